// File: rtl/dma_path_controller.sv
// DMA path controller: grants one LSC request, takes a 128-bit header,
// issues a host command, then streams write beats to the host through a
// FIFO or returns host read beats upstream through a one-entry register.
//
// Ports:
//   clk, rst (async, active-low)
//   lsc_req / lsc_resp        : request level, one-cycle grant pulse
//   lsc_write_*               : header and write-data beats in
//   lsc_read_*                : read beats out
//   hcmd_*                    : host command (rwn, addr, local, len)
//   hwr_*                     : host write beats out (FWFT FIFO head)
//   hrd_*                     : host read beats in
//   busy, err                 : not idle, sticky bad-opcode flag
//
// Optional build macro DPC_STATS_EN adds stat_wr_cnt / stat_rd_cnt.

module dma_path_controller #(
    parameter int WFIFO_DEPTH = 8,
    parameter int WFIFO_AW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lsc_req,
    output logic         lsc_resp,
    input  logic         lsc_write_valid,
    input  logic [127:0] lsc_write_data,
    output logic         lsc_write_ready,
    output logic         lsc_read_valid,
    output logic [127:0] lsc_read_data,
    input  logic         lsc_read_ready,
    output logic         hcmd_valid,
    input  logic         hcmd_ready,
    output logic         hcmd_rwn,
    output logic [39:0]  hcmd_addr,
    output logic [13:0]  hcmd_local,
    output logic [15:0]  hcmd_len,
    output logic         hwr_valid,
    output logic [127:0] hwr_data,
    output logic         hwr_last,
    input  logic         hwr_ready,
    input  logic         hrd_valid,
    input  logic [127:0] hrd_data,
    output logic         hrd_ready,
    output logic         busy,
    output logic         err
`ifdef DPC_STATS_EN
    ,
    output logic [15:0]  stat_wr_cnt,
    output logic [15:0]  stat_rd_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_HDR, S_CMD, S_WDATA, S_RDATA, S_DONE
    } state_t;

    localparam logic [7:0] OP_WR = 8'h03;
    localparam logic [7:0] OP_RD = 8'h01;
    localparam logic [WFIFO_AW:0] FDEPTH = (WFIFO_AW+1)'(WFIFO_DEPTH);

    state_t state_q, state_d;

    logic [13:0]  local_q;
    logic [39:0]  addr_q;
    logic [15:0]  len_q;
    logic         rwn_q;
    logic         err_q;

    logic [127:0]        fifo_mem [WFIFO_DEPTH];
    logic [WFIFO_AW-1:0] wptr_q, rptr_q;
    logic [WFIFO_AW:0]   fcnt_q;

    logic [15:0]  wr_in_cnt, wr_out_cnt, rd_cnt;
    logic [127:0] rd_data_q;
    logic         rd_full_q;

    logic [7:0] op;
    logic op_ok, fifo_full, fifo_empty, last_beat;
    logic hdr_fire, wr_push, wr_pop, hrd_fire, rd_pop;

    assign op         = lsc_write_data[79:72];
    assign op_ok      = (op == OP_WR) || (op == OP_RD);
    assign fifo_full  = (fcnt_q == FDEPTH);
    assign fifo_empty = (fcnt_q == '0);
    assign last_beat  = (wr_out_cnt == len_q - 16'd1);

    assign lsc_resp = (state_q == S_GRANT);
    assign lsc_write_ready =
        (state_q == S_HDR) ||
        ((state_q == S_WDATA) && !fifo_full && (wr_in_cnt < len_q));
    assign hcmd_valid = (state_q == S_CMD);
    assign hcmd_rwn   = rwn_q;
    assign hcmd_addr  = addr_q;
    assign hcmd_local = local_q;
    assign hcmd_len   = len_q;

    assign hwr_valid = (state_q == S_WDATA) && !fifo_empty;
    assign hwr_data  = hwr_valid ? fifo_mem[rptr_q] : '0;
    assign hwr_last  = hwr_valid && last_beat;

    // Register must not be bypassed, so a free slot or a draining
    // register is required; stop accepting once the count is reached.
    assign hrd_ready = (state_q == S_RDATA) && (rd_cnt != len_q) &&
                       (!rd_full_q || lsc_read_ready);
    assign lsc_read_valid = rd_full_q;
    assign lsc_read_data  = rd_data_q;

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

    assign hdr_fire = (state_q == S_HDR) && lsc_write_valid;
    assign wr_push  = (state_q == S_WDATA) && lsc_write_valid &&
                      lsc_write_ready;
    assign wr_pop   = hwr_valid && hwr_ready;
    assign hrd_fire = hrd_valid && hrd_ready;
    assign rd_pop   = rd_full_q && lsc_read_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (lsc_req) state_d = S_GRANT;
            S_GRANT: state_d = S_HDR;
            S_HDR:   if (lsc_write_valid)
                         state_d = op_ok ? S_CMD : S_IDLE;
            S_CMD:   if (hcmd_ready) begin
                         if (len_q == 16'd0) state_d = S_DONE;
                         else if (rwn_q)     state_d = S_RDATA;
                         else                state_d = S_WDATA;
                     end
            S_WDATA: if (wr_pop && last_beat) state_d = S_DONE;
            S_RDATA: if ((rd_cnt == len_q) && !rd_full_q)
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            local_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            rwn_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            wr_in_cnt  <= '0;
            wr_out_cnt <= '0;
            rd_cnt     <= '0;
            rd_data_q  <= '0;
            rd_full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hdr_fire) begin
                if (op_ok) begin
                    local_q <= lsc_write_data[13:0];
                    addr_q  <= lsc_write_data[55:16];
                    len_q   <= lsc_write_data[71:56];
                    rwn_q   <= (op == OP_RD);
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == S_DONE) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                fcnt_q     <= '0;
                wr_in_cnt  <= '0;
                wr_out_cnt <= '0;
                rd_cnt     <= '0;
                rd_full_q  <= 1'b0;
            end else begin
                if (wr_push) begin
                    wptr_q    <= wptr_q + 1'b1;
                    wr_in_cnt <= wr_in_cnt + 16'd1;
                end
                if (wr_pop) begin
                    rptr_q     <= rptr_q + 1'b1;
                    wr_out_cnt <= wr_out_cnt + 16'd1;
                end
                if (wr_push && !wr_pop)
                    fcnt_q <= fcnt_q + 1'b1;
                else if (!wr_push && wr_pop)
                    fcnt_q <= fcnt_q - 1'b1;
                if (hrd_fire) begin
                    rd_data_q <= hrd_data;
                    rd_full_q <= 1'b1;
                    rd_cnt    <= rd_cnt + 16'd1;
                end else if (rd_pop) begin
                    rd_full_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) fifo_mem[wptr_q] <= lsc_write_data;
    end

`ifdef DPC_STATS_EN
    logic done_entry;
    assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else if (done_entry) begin
            if (rwn_q) stat_rd_cnt <= stat_rd_cnt + 16'd1;
            else       stat_wr_cnt <= stat_wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_path_controller.sv
// Scoreboard bench for dma_path_controller: directed transfers push
// expected host commands and beats; negedge monitors pop and compare.

module tb_dma_path_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         lsc_req = 1'b0;
    logic         lsc_resp;
    logic         lsc_write_valid = 1'b0;
    logic [127:0] lsc_write_data = '0;
    logic         lsc_write_ready;
    logic         lsc_read_valid;
    logic [127:0] lsc_read_data;
    logic         lsc_read_ready = 1'b1;
    logic         hcmd_valid;
    logic         hcmd_ready = 1'b1;
    logic         hcmd_rwn;
    logic [39:0]  hcmd_addr;
    logic [13:0]  hcmd_local;
    logic [15:0]  hcmd_len;
    logic         hwr_valid;
    logic [127:0] hwr_data;
    logic         hwr_last;
    logic         hwr_ready = 1'b1;
    logic         hrd_valid = 1'b0;
    logic [127:0] hrd_data = '0;
    logic         hrd_ready;
    logic         busy;
    logic         err;
`ifdef DPC_STATS_EN
    logic [15:0]  stat_wr_cnt;
    logic [15:0]  stat_rd_cnt;
`endif

    dma_path_controller #(.WFIFO_DEPTH(8), .WFIFO_AW(3)) dut (
        .clk(clk), .rst(rst),
        .lsc_req(lsc_req), .lsc_resp(lsc_resp),
        .lsc_write_valid(lsc_write_valid),
        .lsc_write_data(lsc_write_data),
        .lsc_write_ready(lsc_write_ready),
        .lsc_read_valid(lsc_read_valid),
        .lsc_read_data(lsc_read_data),
        .lsc_read_ready(lsc_read_ready),
        .hcmd_valid(hcmd_valid), .hcmd_ready(hcmd_ready),
        .hcmd_rwn(hcmd_rwn), .hcmd_addr(hcmd_addr),
        .hcmd_local(hcmd_local), .hcmd_len(hcmd_len),
        .hwr_valid(hwr_valid), .hwr_data(hwr_data),
        .hwr_last(hwr_last), .hwr_ready(hwr_ready),
        .hrd_valid(hrd_valid), .hrd_data(hrd_data),
        .hrd_ready(hrd_ready),
        .busy(busy), .err(err)
`ifdef DPC_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         last;
    } wbeat_t;

    wbeat_t       hwr_q[$];
    logic [127:0] rd_q[$];
    logic [70:0]  hcmd_q[$];

    int checks = 0;
    int failures = 0;
    int wr_beats = 0;
    logic tog_en = 1'b0;

    wbeat_t       we;
    logic [127:0] re;
    logic [70:0]  ce;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [7:0] op,
        input logic [39:0] a, input logic [13:0] l, input logic [15:0] n);
        return {48'h0, op, n, a, 2'b00, l};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (hwr_valid && hwr_ready) begin
                if (hwr_q.size() == 0) chk("hwr_unexpected", 1, 0);
                else begin
                    we = hwr_q.pop_front();
                    chk("hwr_data", hwr_data, we.d);
                    chk("hwr_last", hwr_last, we.last);
                end
            end
            if (hcmd_valid && hcmd_ready) begin
                if (hcmd_q.size() == 0) chk("hcmd_unexpected", 1, 0);
                else begin
                    ce = hcmd_q.pop_front();
                    chk("hcmd_fields",
                        {hcmd_rwn, hcmd_addr, hcmd_local, hcmd_len}, ce);
                end
            end
            if (lsc_read_valid && lsc_read_ready) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    re = rd_q.pop_front();
                    chk("lsc_read_data", lsc_read_data, re);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) lsc_read_ready = ~lsc_read_ready;
    end

    // All tasks start and end at posedge+1.
    task automatic start_xfer();
        int n = 0;
        lsc_req = 1'b1;
        @(negedge clk);
        while (!lsc_resp && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lsc_resp_seen", lsc_resp, 1);
        @(posedge clk); #1;
        lsc_req = 1'b0;
        chk("lsc_resp_pulse", lsc_resp, 0);
    endtask

    task automatic send_beat(input logic [127:0] d);
        int n = 0;
        lsc_write_valid = 1'b1;
        lsc_write_data  = d;
        @(negedge clk);
        while (!lsc_write_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!lsc_write_ready) chk("wr_ready_timeout", 0, 1);
        @(posedge clk); #1;
        lsc_write_valid = 1'b0;
        wr_beats++;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [39:0] a, input logic [13:0] l,
                            input int len, input logic [127:0] base);
        hcmd_q.push_back({1'b0, a, l, 16'(len)});
        for (int i = 0; i < len; i++) begin
            we.d = base + 128'(i);
            we.last = (i == len - 1);
            hwr_q.push_back(we);
        end
        start_xfer();
        send_beat(mk_hdr(8'h03, a, l, 16'(len)));
        for (int i = 0; i < len; i++) send_beat(base + 128'(i));
    endtask

    logic [127:0] rbeat [3];

    initial begin
        rbeat[0] = 128'hA0A0_0000_0000_0000_0000_0000_0000_1111;
        rbeat[1] = 128'hA1A1_0000_0000_0000_0000_0000_0000_2222;
        rbeat[2] = 128'hA2A2_0000_0000_0000_0000_0000_0000_3333;

        #2;
        chk("reset_outputs_zero",
            |{lsc_resp, lsc_write_ready, lsc_read_valid, lsc_read_data,
              hcmd_valid, hcmd_rwn, hcmd_addr, hcmd_local, hcmd_len,
              hwr_valid, hwr_data, hwr_last, hrd_ready, busy, err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Write, length 4
        do_write(40'h12_3456_7800, 14'h0010, 4,
                 128'hD0D0_0000_0000_0000_0000_0000_0000_0000);
        wait_idle();
        chk("w4_hwr_q_empty", hwr_q.size(), 0);
        chk("w4_hcmd_q_empty", hcmd_q.size(), 0);

        // Write backpressure, length 12
        hwr_ready = 1'b0;
        hcmd_q.push_back({1'b0, 40'h00_0000_1000, 14'h0020, 16'd12});
        for (int i = 0; i < 12; i++) begin
            we.d = 128'hB000 + 128'(i);
            we.last = (i == 11);
            hwr_q.push_back(we);
        end
        start_xfer();
        send_beat(mk_hdr(8'h03, 40'h00_0000_1000, 14'h0020, 16'd12));
        wr_beats = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send_beat(128'hB000 + 128'(i));
            end
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("bp_beats_when_full", wr_beats, 8);
                chk("bp_wr_ready_low", lsc_write_ready, 0);
                @(posedge clk); #1;
                hwr_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_hwr_q_empty", hwr_q.size(), 0);

        // Read, length 3, with toggling upstream ready
        hcmd_q.push_back({1'b1, 40'h00_ABCD_0000, 14'h0100, 16'd3});
        start_xfer();
        send_beat(mk_hdr(8'h01, 40'h00_ABCD_0000, 14'h0100, 16'd3));
        tog_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            rd_q.push_back(rbeat[i]);
            hrd_valid = 1'b1;
            hrd_data  = rbeat[i];
            @(negedge clk);
            while (!hrd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!hrd_ready) chk("hrd_ready_timeout", 0, 1);
            @(posedge clk); #1;
            hrd_valid = 1'b0;
            @(negedge clk);
            chk("rd_latency_valid", lsc_read_valid, 1);
            chk("rd_latency_data", lsc_read_data, rbeat[i]);
            @(posedge clk); #1;
        end
        hrd_valid = 1'b1;
        hrd_data  = 128'hDEAD;
        repeat (4) begin
            @(negedge clk);
            chk("hrd_ready_after_len", hrd_ready, 0);
        end
        @(posedge clk); #1;
        hrd_valid = 1'b0;
        wait_idle();
        tog_en = 1'b0;
        #1 lsc_read_ready = 1'b1;
        @(posedge clk); #1;
        chk("rd_q_empty", rd_q.size(), 0);

        // Bad opcode
        start_xfer();
        send_beat(mk_hdr(8'h05, 40'h1, 14'h1, 16'd2));
        chk("bad_op_idle", busy, 0);
        chk("bad_op_err", err, 1);
        repeat (3) @(posedge clk);
        #1 chk("bad_op_err_sticky", err, 1);
        do_write(40'h00_0000_2000, 14'h0030, 2,
                 128'hC0C0_0000_0000_0000_0000_0000_0000_0000);
        wait_idle();
        chk("after_bad_hwr_q_empty", hwr_q.size(), 0);
        chk("after_bad_err_kept", err, 1);

        // Length 0 with hcmd stall
        hcmd_ready = 1'b0;
        hcmd_q.push_back({1'b0, 40'h00_0000_3000, 14'h0040, 16'd0});
        start_xfer();
        send_beat(mk_hdr(8'h03, 40'h00_0000_3000, 14'h0040, 16'd0));
        repeat (5) begin
            @(negedge clk);
            chk("stall_hcmd_valid", hcmd_valid, 1);
            chk("stall_hcmd_addr", hcmd_addr, 40'h00_0000_3000);
        end
        @(posedge clk); #1;
        hcmd_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("len0_busy_in_done", busy, 1);
        @(posedge clk); #1;
        chk("len0_idle", busy, 0);
        chk("len0_hcmd_q_empty", hcmd_q.size(), 0);

        // Reset mid-write
        hwr_ready = 1'b0;
        hcmd_q.push_back({1'b0, 40'h00_0000_4000, 14'h0050, 16'd6});
        start_xfer();
        send_beat(mk_hdr(8'h03, 40'h00_0000_4000, 14'h0050, 16'd6));
        send_beat(128'hE000);
        send_beat(128'hE001);
        chk("rst_mid_hcmd_done", hcmd_q.size(), 0);
        chk("rst_mid_fifo_holding", hwr_valid, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs_zero",
            |{lsc_resp, lsc_write_ready, lsc_read_valid, lsc_read_data,
              hcmd_valid, hcmd_rwn, hcmd_addr, hcmd_local, hcmd_len,
              hwr_valid, hwr_data, hwr_last, hrd_ready, busy, err}, 0);
        hwr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        hwr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_fifo_empty", hwr_valid, 0);
        end
        chk("post_rst_err", err, 0);

        chk("end_hwr_q_empty", hwr_q.size(), 0);
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_hcmd_q_empty", hcmd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
